serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor computing a − b on WIDTH-bit unsigned operands, one bit per clock, LSB first. It is the subtraction counterpart to the arithmetic half-adder cells: a single-bit difference/borrow cell iterated over time behind a start/done handshake. It serves as the area-minimal subtract path in datapaths where latency is not critical.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a subtraction; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when diff and bout become valid.
- diff  output  WIDTH  a − b mod 2^WIDTH; held until the next result.
- bout  output  1  final borrow; 1 iff a < b unsigned.
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. The reset state is IDLE.
- IDLE or DONE with start=1:
  - load ra←a and rb←b, clear the borrow register br and the bit counter cnt;
  - next state SHIFT.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: next state IDLE.
- SHIFT, each cycle:
  - d = ra[0]^rb[0]^br;
  - br ← (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br);
  - shift d into the MSB of an internal result register rr;
  - shift ra and rb right by 1;
  - cnt ← cnt+1.
- SHIFT with cnt == WIDTH−1: on that edge, load diff ← the final rr (including this cycle's d), load bout ← the final borrow, and go to DONE.
- start in SHIFT is ignored. a and b are don't-care outside the accepting edge.
- cnt width is $clog2(WIDTH).
- diff and bout change only on entry to DONE. Between results they hold their values.
- Reset asserted at any time returns the block to IDLE asynchronously and clears every register. A pending operation is discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0.
- Let edge E0 be the edge where start is accepted.
- busy=1 from after E0 through after edge E0+WIDTH−1, which is exactly WIDTH cycles.
- done=1 for exactly one cycle, after edge E0+WIDTH. diff and bout are valid in that same cycle.
- Latency from accepting edge to done is WIDTH cycles.
- Back-to-back throughput: start held during the DONE cycle is accepted. The next result follows every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - the ovf port exists;
  - a[WIDTH−1] and b[WIDTH−1] are captured at start into registers sa and sb;
  - on entry to DONE, ovf ← (sa^sb) & (sa^diff_next[WIDTH−1]);
  - ovf holds like diff and resets to 0.
- SERIAL_SUB_OVF_EN undefined: the ovf port, sa, sb and the associated logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, start pulsed one cycle -> after 8 cycles, done pulse with diff=0x37, bout=0; busy high for exactly 8 cycles.
- a=0x23, b=0x5A -> diff=0xC9, bout=1. a=0x00, b=0x01 -> diff=0xFF, bout=1. a=b=0xA5 -> diff=0x00, bout=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x10, b=0x20 -> diff=0xF0, ovf=0.
- Start re-pulsed with a=0xFF, b=0x00 while busy -> ignored. The original operation still returns its own result (0x37 for 0x5A−0x23).
- Start held high across the DONE cycle with new operands 0x10−0x01 -> second done exactly 9 cycles after the first, diff=0x0F.
- rst_n pulled low at cycle 4 of SHIFT -> busy, done, diff and bout are 0 immediately. No done pulse follows. A fresh start after release completes normally.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives start, a, b; observes busy, done, diff, bout (and ovf)
//   slave  : the subtractor side of the same signals
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, bout);
   modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial a - b on WIDTH-bit unsigned operands, one bit per clock, LSB first.
// A single difference/borrow cell is iterated WIDTH times behind a start/done
// handshake; the result appears WIDTH cycles after the accepting edge.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears all state
//   bus    : serial_subtractor_if.slave
//            start (in)  request, sampled only in IDLE or DONE
//            a, b  (in)  minuend / subtrahend, captured on the accepting edge
//            busy  (out) high while shifting
//            done  (out) one-cycle pulse when diff/bout are updated
//            diff  (out) a - b mod 2^WIDTH, held until the next result
//            bout  (out) final borrow, 1 iff a < b
//            ovf   (out) signed overflow, only with SERIAL_SUB_OVF_EN
//
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag).
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rr;
   logic             br;
   logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
   logic             sa;
   logic             sb;
`endif

   // One full-subtractor cell acting on the current LSBs plus the borrow.
   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] rr_next;

   always_comb begin
      d       = ra[0] ^ rb[0] ^ br;
      br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
      // Difference bits enter at the MSB, so after WIDTH shifts bit 0 sits
      // at rr[0].
      rr_next = {d, rr[WIDTH-1:1]};
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values; the async reset clears the small operand
   // and result registers too, since a discarded operation must leave no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         rr       <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.diff <= '0;
         bus.bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         sa       <= 1'b0;
         sb       <= 1'b0;
         bus.ovf  <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  ra       <= bus.a;
                  rb       <= bus.b;
                  br       <= 1'b0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  sa       <= bus.a[WIDTH-1];
                  sb       <= bus.b[WIDTH-1];
`endif
               end else if (state == DONE) begin
                  state <= IDLE;
               end
            end

            SHIFT: begin
               br  <= br_next;
               rr  <= rr_next;
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               cnt <= cnt + 1'b1;
               // Last bit: publish this cycle's complete result directly.
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.diff <= rr_next;
                  bus.bout <= br_next;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  // Overflow only when operand signs differ and the result
                  // sign disagrees with the minuend.
                  bus.ovf  <= (sa ^ sb) & (sa ^ rr_next[WIDTH-1]);
`endif
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands, not from the bit-serial cell.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the ovf checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned full;
      full = (int'(a) - int'(b) + (1 << W)) % (1 << W);
      return full[W-1:0];
   endfunction

   function automatic logic model_bout(input logic [W-1:0] a, input logic [W-1:0] b);
      return (int'(a) < int'(b));
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa_val;
      int sb_val;
      int res;
      sa_val = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb_val = b[W-1] ? int'(b) - (1 << W) : int'(b);
      res    = sa_val - sb_val;
      return (res > (1 << (W - 1)) - 1) || (res < -(1 << (W - 1)));
   endfunction

   function automatic logic read_ovf();
`ifdef SERIAL_SUB_OVF_EN
      return bus.ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Drives one operation from the current cycle and reports what was seen.
   // Called at #1 after a rising edge. Returns at #1 after the done edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse,
                        output logic [W-1:0] d, output logic bo, output logic ov,
                        output int lat, output int busy_cnt, output bit got);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      lat       = 0;
      busy_cnt  = 0;
      got       = 1'b0;
      d         = '0;
      bo        = 1'b0;
      ov        = 1'b0;
      while (!got && lat <= W + 4) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            got = 1'b1;
            d   = bus.diff;
            bo  = bus.bout;
            ov  = read_ovf();
         end else begin
            if (repulse && lat == 3) begin
               bus.start = 1'b1;
               bus.a     = 8'hFF;
               bus.b     = 8'h00;
            end else begin
               bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
         end
      end
      bus.start = 1'b0;
   endtask

   // Compares one completed operation against the model.
   task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] d, input logic bo, input logic ov,
                           input int lat, input int busy_cnt, input bit got);
      vectors++;
      if (got !== 1'b1) begin
         miscompares++;
         $display("FAIL %s done: no done pulse within %0d cycles", name, W + 4);
      end
      vectors++;
      if (d !== model_diff(a, b)) begin
         miscompares++;
         $display("FAIL %s diff: %h-%h got %h want %h", name, a, b, d, model_diff(a, b));
      end
      vectors++;
      if (bo !== model_bout(a, b)) begin
         miscompares++;
         $display("FAIL %s bout: %h-%h got %b want %b", name, a, b, bo, model_bout(a, b));
      end
`ifdef SERIAL_SUB_OVF_EN
      vectors++;
      if (ov !== model_ovf(a, b)) begin
         miscompares++;
         $display("FAIL %s ovf: %h-%h got %b want %b", name, a, b, ov, model_ovf(a, b));
      end
`else
      if (ov !== 1'b0) $display("note: ovf reads nonzero with the overflow feature disabled");
`endif
      vectors++;
      if (lat != W) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, W);
      end
      vectors++;
      if (busy_cnt != W) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, W);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.diff, bus.bout, read_ovf()} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                  bus.busy, bus.done, bus.diff, bus.bout, read_ovf());
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[6] = '{8'h5A, 8'h23, 8'h00, 8'hA5, 8'h80, 8'h10};
      logic [W-1:0] tb_[6] = '{8'h23, 8'h5A, 8'h01, 8'hA5, 8'h01, 8'h20};
      logic [W-1:0] d;
      logic bo, ov;
      int lat, bc;
      bit got;
      for (int i = 0; i < 6; i++) begin
         do_op(ta[i], tb_[i], 1'b0, d, bo, ov, lat, bc, got);
         check_op("directed", ta[i], tb_[i], d, bo, ov, lat, bc, got);
         // done must be a single-cycle pulse and the result must hold.
         @(posedge clk);
         #1;
         vectors++;
         if (bus.done !== 1'b0 || bus.diff !== model_diff(ta[i], tb_[i])) begin
            miscompares++;
            $display("FAIL done_pulse_hold: done=%b diff=%h want 0 %h",
                     bus.done, bus.diff, model_diff(ta[i], tb_[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, d;
      logic bo, ov;
      int lat, bc;
      bit got;
      for (int i = 0; i < 30; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         do_op(a, b, 1'b0, d, bo, ov, lat, bc, got);
         check_op("random", a, b, d, bo, ov, lat, bc, got);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] d;
      logic bo, ov;
      int lat, bc;
      bit got;
      do_op(8'h5A, 8'h23, 1'b1, d, bo, ov, lat, bc, got);
      check_op("ignore_start", 8'h5A, 8'h23, d, bo, ov, lat, bc, got);
      @(posedge clk);
      #1;
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_start_no_restart: busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d;
      logic bo, ov;
      int lat, bc, gap;
      bit got, seen, held_ok;
      do_op(8'h5A, 8'h23, 1'b0, d, bo, ov, lat, bc, got);
      check_op("b2b_first", 8'h5A, 8'h23, d, bo, ov, lat, bc, got);
      // Still in the DONE cycle: offer the next operation now.
      bus.start = 1'b1;
      bus.a     = 8'h10;
      bus.b     = 8'h01;
      gap       = 0;
      seen      = 1'b0;
      held_ok   = 1'b1;
      while (!seen && gap <= W + 5) begin
         @(posedge clk);
         #1;
         gap++;
         bus.start = 1'b0;
         if (bus.done) seen = 1'b1;
         else if (bus.diff !== 8'h37) held_ok = 1'b0;
      end
      vectors++;
      if (!seen || gap != W + 1) begin
         miscompares++;
         $display("FAIL b2b_gap: done seen=%b after %0d cycles want %0d", seen, gap, W + 1);
      end
      vectors++;
      if (bus.diff !== model_diff(8'h10, 8'h01)) begin
         miscompares++;
         $display("FAIL b2b_diff: got %h want %h", bus.diff, model_diff(8'h10, 8'h01));
      end
      vectors++;
      if (!held_ok) begin
         miscompares++;
         $display("FAIL b2b_hold: diff changed before second done, want 37 held");
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] d;
      logic bo, ov;
      int lat, bc;
      bit got, spurious;
      do_op(8'h23, 8'h5A, 1'b0, d, bo, ov, lat, bc, got);
      check_op("pre_reset", 8'h23, 8'h5A, d, bo, ov, lat, bc, got);
      bus.start = 1'b1;
      bus.a     = 8'h80;
      bus.b     = 8'h01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.diff, bus.bout, read_ovf()} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                  bus.busy, bus.done, bus.diff, bus.bout, read_ovf());
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) spurious = 1'b1;
      end
      vectors++;
      if (spurious) begin
         miscompares++;
         $display("FAIL mid_reset_discard: activity after reset, want none");
      end
      do_op(8'h5A, 8'h23, 1'b0, d, bo, ov, lat, bc, got);
      check_op("post_reset", 8'h5A, 8'h23, d, bo, ov, lat, bc, got);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
